// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  localparam int IMEM_DEPTH_C  = 1024;
  localparam int IMEM_ADDR_W_C = 10;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects four stream bytes into one little-endian word.
// Bytes shift in from the top, so after four accepts byte 0 sits in [7:0].
module imem_loader_byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  // Next index / assembly value: clear wins, otherwise shift on accept.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept) begin
      idx_d  = idx_q + 2'd1;
      word_d = {byte_in, word_q[DATA_W-1:8]};
    end
  end

  // Index and assembly register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // Pulses on the accept that completes the word; the word is whole next cycle.
  assign word_full = accept && !clear && (idx_q == 2'd3);
  assign word      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory, holding the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = IMEM_DEPTH_C,
  parameter int ADDR_W     = IMEM_ADDR_W_C,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   loaded_words
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  loader_state_t   state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] loaded_q, loaded_d;
  logic            err_q, err_d;
  logic            we_q, busy_q, done_q, hold_q;
  logic            pk_clear, pk_full, accept;

  assign byte_ready = (state_q == RECV);
  assign accept     = byte_valid && byte_ready;

  imem_loader_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (pk_clear),
    .accept    (accept),
    .byte_in   (byte_data),
    .word      (imem_wdata),
    .word_full (pk_full)
  );

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    pk_clear = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (word_count > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            cnt_d    = word_count;
            loaded_d = '0;
            pk_clear = 1'b1;
            state_d  = (word_count == '0) ? DONE : RECV;
          end
        end
      end
      RECV: begin
        if (pk_full) state_d = WRITE;
      end
      WRITE: begin
        loaded_d = loaded_q + ONE_L;
        state_d  = (loaded_d == cnt_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered status decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      we_q     <= (state_d == WRITE);
      busy_q   <= (state_d == RECV) || (state_d == WRITE);
      done_q   <= (state_d == DONE);
      hold_q   <= (state_d != DONE);
    end
  end

  // Word pointer and written-word count advance together, so share a register.
  assign imem_addr    = loaded_q[ADDR_W-1:0];
  assign imem_we      = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cpu_hold     = hold_q;
  assign err          = err_q;
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
module tb_imem_loader;

  logic        clk, reset, start, byte_valid;
  logic [10:0] word_count;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_hold, busy, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] loaded_words;

  int total = 0;
  int bad   = 0;
  int rdy_viol = 0;
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .loaded_words(loaded_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: log every memory write and any byte_ready seen during one.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      if (byte_ready) rdy_viol++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [10:0] cnt);
    start = 1'b1;
    word_count = cnt;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until taken; optional idle cycle afterwards.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    acc = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = byte_ready;
      tick();
    end
    if (!acc) chk1("byte_accept_timeout", acc, 1'b1);
    if (gap) begin
      byte_valid = 1'b0;
      tick();
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk1(tag, done, 1'b1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rdy_viol = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; word_count = '0;
    byte_valid = 1'b0; byte_data = '0;
    #2 reset = 1'b0;
    tick();
    // Reset state
    chk1("rst_hold", cpu_hold, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_we", imem_we, 1'b0);
    chk1("rst_ready", byte_ready, 1'b0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_loaded", 32'(loaded_words), 32'd0);
    reset = 1'b1;
    tick();

    // 1: single word, exact timing
    do_start(11'd1);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_ready", byte_ready, 1'b1);
    chk1("t1_hold", cpu_hold, 1'b1);
    byte_valid = 1'b1; byte_data = 8'h13; tick();
    byte_data = 8'h05; tick();
    byte_data = 8'h50; tick();
    byte_data = 8'h00; tick();
    chk1("t1_we", imem_we, 1'b1);
    chk1("t1_ready_wr", byte_ready, 1'b0);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    chk("t1_wdata", imem_wdata, 32'h00500513);
    byte_valid = 1'b0;
    tick();
    chk1("t1_done", done, 1'b1);
    chk1("t1_hold_rel", cpu_hold, 1'b0);
    chk1("t1_we_off", imem_we, 1'b0);
    chk("t1_loaded", 32'(loaded_words), 32'd1);
    chk("t1_nwr", wr_addr.size(), 32'd1);

    // 6: reload from DONE
    clear_log();
    do_start(11'd1);
    chk1("t6_done_drop", done, 1'b0);
    chk1("t6_hold_rise", cpu_hold, 1'b1);
    byte_valid = 1'b1; byte_data = 8'hEF; tick();
    byte_data = 8'hBE; tick();
    byte_data = 8'hAD; tick();
    byte_data = 8'hDE; tick();
    chk1("t6_we", imem_we, 1'b1);
    chk("t6_wdata", imem_wdata, 32'hDEADBEEF);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    byte_valid = 1'b0;
    tick();
    chk1("t6_done", done, 1'b1);

    // 2: gapped stream
    clear_log();
    do_start(11'd2);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    wait_done("t2_done", 40);
    chk("t2_nwr", wr_addr.size(), 32'd2);
    chk("t2_a0", 32'(wr_addr[0]), 32'd0);
    chk("t2_d0", wr_data[0], 32'h04030201);
    chk("t2_a1", 32'(wr_addr[1]), 32'd1);
    chk("t2_d1", wr_data[1], 32'h08070605);
    chk("t2_rdy_in_write", rdy_viol, 32'd0);
    chk("t2_loaded", 32'(loaded_words), 32'd2);

    // 3a: zero count
    clear_log();
    do_start(11'd0);
    chk1("t3a_done", done, 1'b1);
    chk("t3a_loaded", 32'(loaded_words), 32'd0);
    tick();
    chk("t3a_nwr", wr_addr.size(), 32'd0);

    // 3b: oversize count from IDLE
    reset = 1'b0; tick(); reset = 1'b1; tick();
    do_start(11'd1025);
    chk1("t3b_err", err, 1'b1);
    chk1("t3b_busy", busy, 1'b0);
    chk1("t3b_hold", cpu_hold, 1'b1);
    chk1("t3b_ready", byte_ready, 1'b0);
    tick();
    chk1("t3b_err_sticky", err, 1'b1);

    // 3c: full-depth load
    clear_log();
    do_start(11'd1024);
    chk1("t3c_err_clr", err, 1'b0);
    for (int i = 0; i < 4096; i++) send_byte(8'(i), 1'b0);
    byte_valid = 1'b0;
    wait_done("t3c_done", 10);
    chk("t3c_nwr", wr_addr.size(), 32'd1024);
    chk("t3c_last_addr", 32'(wr_addr[1023]), 32'd1023);
    chk("t3c_last_data", wr_data[1023], 32'hFFFEFDFC);
    chk("t3c_loaded", 32'(loaded_words), 32'd1024);

    // 4: start ignored mid-RECV
    clear_log();
    do_start(11'd3);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    byte_valid = 1'b0;
    do_start(11'd5);
    chk1("t4_busy", busy, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h50 + i), 1'b0);
    byte_valid = 1'b0;
    wait_done("t4_done", 20);
    repeat (20) tick();
    chk("t4_nwr", wr_addr.size(), 32'd3);
    chk("t4_d0", wr_data[0], 32'h44332211);
    chk("t4_loaded", 32'(loaded_words), 32'd3);

    // 5: reset mid-load, then clean reload
    do_start(11'd3);
    for (int i = 0; i < 6; i++) send_byte(8'hF0, 1'b0);
    byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk1("t5_hold", cpu_hold, 1'b1);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_done", done, 1'b0);
    chk("t5_loaded", 32'(loaded_words), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    clear_log();
    do_start(11'd1);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    byte_valid = 1'b0;
    wait_done("t5_redone", 10);
    chk("t5_nwr", wr_addr.size(), 32'd1);
    chk("t5_a0", 32'(wr_addr[0]), 32'd0);
    chk("t5_d0", wr_data[0], 32'hDDCCBBAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
